// File: rtl/idli_pkg.sv
// Shared types and constants for the idli retire-trace capture stage.
package idli_pkg;

  localparam int TRC_NIBBLES = 4;
  localparam int TRC_PC_W    = 16;

  typedef struct packed {
    logic [TRC_PC_W-1:0] pc;
    logic                skip;
  } trace_entry_t;

endpackage

// File: rtl/idli_trace_fifo_m.sv
// DEPTH-entry synchronous FIFO of trace entries.
// Uses extra-MSB pointers, a registered read pointer and a combinational head mux.
module idli_trace_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_entry_t data,
  input  logic         rdy,
  output logic         vld,
  output trace_entry_t head,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  trace_entry_t mem [DEPTH];
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && rdy;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign vld  = !empty;
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage is cleared on reset too, so every register in the block starts at 0;
  // sequential state always uses <= so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/idli_trace_m.sv
// Retire-trace capture: deserialises the nibble-serial PC, queues {PC, skip} per
// retired instruction, counts retires and keeps sticky overflow/protocol-error flags.
module idli_trace_m
  import idli_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_ADJ = 1
) (
  input  logic        i_trc_gck,
  input  logic        i_trc_rst,
  input  logic        i_trc_en,
  input  logic        i_trc_nib_first,
  input  logic [3:0]  i_trc_pc,
  input  logic        i_trc_done,
  input  logic        i_trc_skip,
  output logic        o_trc_vld,
  input  logic        i_trc_rdy,
  output logic [15:0] o_trc_pc,
  output logic        o_trc_skip,
  output logic [15:0] o_trc_ret_cnt,
  output logic        o_trc_ovf,
  output logic        o_trc_err,
  input  logic        i_trc_clr
);

  localparam int              NW       = $clog2(TRC_NIBBLES);
  localparam logic [NW-1:0]   LAST_NIB = NW'(TRC_NIBBLES - 1);
  localparam logic [15:0]     ADJ      = 16'(PC_ADJ);

  logic [15:0]   pc_q;
  logic [15:0]   pc_d;
  logic [NW-1:0] nib_q;
  logic [NW-1:0] nib_idx;
  logic          push;
  logic          proto_err;
  logic          clr;
  logic          drop;
  logic          fifo_vld;
  trace_entry_t  wr_entry;
  trace_entry_t  head;

  assign pc_d      = {i_trc_pc, pc_q[15:4]};
  assign nib_idx   = i_trc_nib_first ? '0 : nib_q;
  assign push      = i_trc_en && i_trc_done && (nib_idx == LAST_NIB);
  assign proto_err = i_trc_en && i_trc_done && (nib_idx != LAST_NIB);
  assign clr       = i_trc_en && i_trc_clr;
  assign wr_entry  = '{pc: pc_d - ADJ, skip: i_trc_skip};

  always_ff @(posedge i_trc_gck or posedge i_trc_rst) begin
    if (i_trc_rst) begin
      pc_q  <= '0;
      nib_q <= '0;
    end else if (i_trc_en) begin
      pc_q  <= pc_d;
      nib_q <= i_trc_nib_first ? NW'(1) : nib_q + NW'(1);
    end
  end

  // Dropped entries still count as retired; set events beat a same-cycle clear.
  always_ff @(posedge i_trc_gck or posedge i_trc_rst) begin
    if (i_trc_rst) begin
      o_trc_ret_cnt <= '0;
      o_trc_ovf     <= 1'b0;
      o_trc_err     <= 1'b0;
    end else begin
      if (push) begin
        o_trc_ret_cnt <= o_trc_ret_cnt + 16'd1;
      end
      o_trc_ovf <= drop      || (o_trc_ovf && !clr);
      o_trc_err <= proto_err || (o_trc_err && !clr);
    end
  end

  idli_trace_fifo_m #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk (i_trc_gck),
    .rst (i_trc_rst),
    .push(push),
    .data(wr_entry),
    .rdy (i_trc_rdy),
    .vld (fifo_vld),
    .head(head),
    .drop(drop)
  );

  assign o_trc_vld  = fifo_vld;
  assign o_trc_pc   = head.pc;
  assign o_trc_skip = head.skip;

endmodule

// File: tb/tb_idli_trace_m.sv
// Self-checking bench for idli_trace_m: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_idli_trace_m;

  localparam int DEPTH  = 4;
  localparam int PC_ADJ = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        nib_first;
  logic [3:0]  pc_nib;
  logic        done;
  logic        skip;
  logic        vld;
  logic        rdy;
  logic [15:0] pc;
  logic        skip_out;
  logic [15:0] ret_cnt;
  logic        ovf;
  logic        err;
  logic        clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idli_trace_m #(
    .DEPTH (DEPTH),
    .PC_ADJ(PC_ADJ)
  ) dut (
    .i_trc_gck      (clk),
    .i_trc_rst      (rst),
    .i_trc_en       (en),
    .i_trc_nib_first(nib_first),
    .i_trc_pc       (pc_nib),
    .i_trc_done     (done),
    .i_trc_skip     (skip),
    .o_trc_vld      (vld),
    .i_trc_rdy      (rdy),
    .o_trc_pc       (pc),
    .o_trc_skip     (skip_out),
    .o_trc_ret_cnt  (ret_cnt),
    .o_trc_ovf      (ovf),
    .o_trc_err      (err),
    .i_trc_clr      (clr)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [15:0] pc;
    logic        skip;
  } ent_t;

  ent_t        m_q[$];
  logic [3:0]  m_nibs[$];   // last four PC nibbles seen, oldest (LSB) first
  int          m_pos;       // index the next enabled cycle will carry
  int          m_cnt;
  logic        m_ovf;
  logic        m_err;

  function automatic void model_reset();
    m_q.delete();
    m_nibs.delete();
    m_pos = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic logic [15:0] model_pc();
    int v = 0;
    for (int i = 0; i < m_nibs.size(); i++) begin
      v += int'(m_nibs[i]) * (1 << (4 * (4 - m_nibs.size() + i)));
    end
    return 16'(v);
  endfunction

  function automatic void model_step(input logic e, input logic f, input logic [3:0] n,
                                     input logic d, input logic s, input logic r,
                                     input logic c);
    bit   do_pop;
    bit   do_push = 0;
    bit   bad     = 0;
    bit   lost    = 0;
    int   idx;
    ent_t ent;
    do_pop = (m_q.size() > 0) && r;
    if (e) begin
      idx   = f ? 0 : m_pos;
      m_pos = (idx + 1) % 4;
      m_nibs.push_back(n);
      if (m_nibs.size() > 4) void'(m_nibs.pop_front());
      if (d) begin
        if (idx == 3) begin
          do_push  = 1;
          ent.pc   = 16'((int'(model_pc()) - PC_ADJ + 65536) % 65536);
          ent.skip = s;
          m_cnt    = (m_cnt + 1) % 65536;
        end else begin
          bad = 1;
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() >= DEPTH) lost = 1;
      else m_q.push_back(ent);
    end
    if (bad) m_err = 1'b1;
    else if (e && c) m_err = 1'b0;
    if (lost) m_ovf = 1'b1;
    else if (e && c) m_ovf = 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; drives one cycle and returns at the next posedge+1.
  task automatic drive(input logic e, input logic f, input logic [3:0] n, input logic d,
                       input logic s, input logic r, input logic c);
    en = e; nib_first = f; pc_nib = n; done = d; skip = s; rdy = r; clr = c;
    model_step(e, f, n, d, s, r, c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, r, 1'b0);
  endtask

  // Feed a raw (unadjusted) PC LSB nibble first, done on the last nibble.
  task automatic retire(input logic [15:0] raw, input logic s, input logic rdy_last);
    logic [15:0] v;
    v = raw;
    drive(1'b1, 1'b1, v[3:0],   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, v[7:4],   1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, v[11:8],  1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, v[15:12], 1'b1, s,    rdy_last, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 0; nib_first = 0; pc_nib = 0; done = 0; skip = 0; rdy = 0; clr = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    en = 0; nib_first = 0; pc_nib = 0; done = 0; skip = 0; rdy = 0; clr = 0;
    model_reset();
    #2;
    checks++; if (vld !== 1'b0)      begin errors++; $display("FAIL reset_vld: got %b want 0", vld); end
    checks++; if (pc !== 16'h0)      begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
    checks++; if (skip_out !== 1'b0) begin errors++; $display("FAIL reset_skip: got %b want 0", skip_out); end
    checks++; if (ret_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0000", ret_cnt); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL basic_no_early_vld: got %b want 0", vld); end
    drive(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++; if (vld !== 1'b1)      begin errors++; $display("FAIL basic_vld: got %b want 1", vld); end
    checks++; if (pc !== 16'h1233)   begin errors++; $display("FAIL basic_pc: got %h want 1233", pc); end
    checks++; if (skip_out !== 1'b0) begin errors++; $display("FAIL basic_skip: got %b want 0", skip_out); end
    checks++; if (ret_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", ret_cnt); end
    idle(1'b1);
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b want 0", vld); end
  endtask

  task automatic test_gap();
    drive(1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++; if (vld !== 1'b1)      begin errors++; $display("FAIL gap_vld: got %b want 1", vld); end
    checks++; if (pc !== 16'h1233)   begin errors++; $display("FAIL gap_pc: got %h want 1233", pc); end
    checks++; if (skip_out !== 1'b1) begin errors++; $display("FAIL gap_skip: got %b want 1", skip_out); end
    checks++; if (ret_cnt !== 16'd2) begin errors++; $display("FAIL gap_cnt: got %0d want 2", ret_cnt); end
    checks++; if (err !== 1'b0)      begin errors++; $display("FAIL gap_err: got %b want 0", err); end
    idle(1'b1);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 5; k++) retire(16'h0011 + 16'(k), 1'(k), 1'b0);
    checks++; if (ovf !== 1'b1)      begin errors++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    checks++; if (ret_cnt !== 16'd5) begin errors++; $display("FAIL ovf_cnt: got %0d want 5", ret_cnt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (vld !== 1'b1 || pc !== 16'h0010 + 16'(k) || skip_out !== 1'(k)) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: got vld=%b pc=%h skip=%b want vld=1 pc=%h skip=%b",
                 k, vld, pc, skip_out, 16'h0010 + 16'(k), 1'(k));
      end
      idle(1'b1);
    end
    checks++; if (vld !== 1'b0) begin errors++; $display("FAIL ovf_empty_vld: got %b want 0", vld); end
    checks++; if (pc !== 16'h0) begin errors++; $display("FAIL ovf_empty_pc: got %h want 0000", pc); end
  endtask

  task automatic test_full_pop();
    int n = 0;
    do_reset();
    for (int k = 0; k < 4; k++) retire(16'h0101 + 16'(k), 1'b0, 1'b0);
    retire(16'h0105, 1'b0, 1'b1);
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL fullpop_ovf: got %b want 0", ovf); end
    checks++; if (ret_cnt !== 16'd5) begin errors++; $display("FAIL fullpop_cnt: got %0d want 5", ret_cnt); end
    while (vld === 1'b1 && n < 10) begin
      checks++;
      if (pc !== 16'h0101 + 16'(n)) begin
        errors++;
        $display("FAIL fullpop_order[%0d]: got %h want %h", n, pc, 16'h0101 + 16'(n));
      end
      idle(1'b1);
      n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL fullpop_occupancy: got %0d want 4", n); end
  endtask

  task automatic test_err();
    logic [15:0] cnt_before;
    cnt_before = ret_cnt;
    drive(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (err !== 1'b1)          begin errors++; $display("FAIL err_set: got %b want 1", err); end
    checks++; if (vld !== 1'b0)          begin errors++; $display("FAIL err_no_push: got %b want 0", vld); end
    checks++; if (ret_cnt !== cnt_before) begin errors++; $display("FAIL err_cnt: got %0d want %0d", ret_cnt, cnt_before); end
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", err); end
    drive(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", err); end
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reclr: got %b want 0", err); end
  endtask

  task automatic test_pc_wrap();
    retire(16'h0000, 1'b0, 1'b0);
    checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL pc_wrap: got %h want ffff", pc); end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    retire(16'h0021, 1'b0, 1'b0);
    retire(16'h0022, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (err !== 1'b1 || vld !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: got err=%b vld=%b want 1 1", err, vld);
    end
    rst = 1'b1;
    #2;
    checks++; if (vld !== 1'b0)      begin errors++; $display("FAIL rstmid_vld: got %b want 0", vld); end
    checks++; if (pc !== 16'h0)      begin errors++; $display("FAIL rstmid_pc: got %h want 0000", pc); end
    checks++; if (ret_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_cnt: got %h want 0000", ret_cnt); end
    checks++; if (err !== 1'b0 || ovf !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got err=%b ovf=%b want 0 0", err, ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    drive(1'b1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (vld !== 1'b1 || pc !== 16'hABBD) begin
      errors++; $display("FAIL rstmid_free_run: got vld=%b pc=%h want 1 abbd", vld, pc);
    end
    checks++; if (ret_cnt !== 16'd1 || err !== 1'b0) begin
      errors++; $display("FAIL rstmid_cnt_after: got cnt=%0d err=%b want 1 0", ret_cnt, err);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic        exp_skip;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 6) == 0), 4'($urandom),
            1'($urandom_range(0, 9) < 4), 1'($urandom), 1'($urandom_range(0, 9) < 4),
            1'($urandom_range(0, 19) == 0));
      exp_pc   = (m_q.size() > 0) ? m_q[0].pc : 16'h0;
      exp_skip = (m_q.size() > 0) ? m_q[0].skip : 1'b0;
      checks++; if (vld !== (m_q.size() > 0)) begin
        errors++; $display("FAIL rand_vld @%0d: got %b want %b", cyc, vld, m_q.size() > 0);
      end
      checks++; if (pc !== exp_pc || skip_out !== exp_skip) begin
        errors++; $display("FAIL rand_head @%0d: got %h/%b want %h/%b", cyc, pc, skip_out, exp_pc, exp_skip);
      end
      checks++; if (ret_cnt !== 16'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt @%0d: got %0d want %0d", cyc, ret_cnt, m_cnt);
      end
      checks++; if (ovf !== m_ovf || err !== m_err) begin
        errors++; $display("FAIL rand_flags @%0d: got ovf=%b err=%b want %b %b", cyc, ovf, err, m_ovf, m_err);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_gap();
    test_overflow();
    test_full_pop();
    test_err();
    test_pc_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
